// File: rtl/dpram_sync.sv
// rtl/dpram_sync.sv - single-clock true dual-port sector buffer RAM
module dpram_sync #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic                  wren_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic                  wren_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports share one process so a same-address collision resolves to port B
    // (its write is scheduled last); reads sample the pre-edge contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (wren_a) begin
                mem[address_a] <= data_a;
                q_a            <= data_a;
            end else begin
                q_a <= mem[address_a];
            end

            if (wren_b) begin
                mem[address_b] <= data_b;
                q_b            <= data_b;
            end else begin
                q_b <= mem[address_b];
            end
        end
    end

endmodule

// File: tb/tb_dpram_sync.sv
// tb/tb_dpram_sync.sv - directed self-checking bench for dpram_sync
module tb_dpram_sync;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] address_a;
    logic       wren_a;
    logic [7:0] data_a;
    logic [7:0] q_a;
    logic [8:0] address_b;
    logic       wren_b;
    logic [7:0] data_b;
    logic [7:0] q_b;

    int checks = 0;
    int errors = 0;

    dpram_sync #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .address_a (address_a),
        .wren_a    (wren_a),
        .data_a    (data_a),
        .q_a       (q_a),
        .address_b (address_b),
        .wren_b    (wren_b),
        .data_b    (data_b),
        .q_b       (q_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wren_a = 1'b0;
        wren_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1; address_a = '0; wren_a = 1'b0; data_a = '0;
        address_b = '0; wren_b = 1'b0; data_b = '0;

        tick();
        check("reset_q_a", q_a, 8'h00);
        check("reset_q_b", q_b, 8'h00);
        reset = 1'b0;

        // Basic write on A, boundary address, readback on B
        wren_a = 1'b1; address_a = 9'h000; data_a = 8'h5A;
        tick();
        check("basic_wt_a", q_a, 8'h5A);
        address_a = 9'h1FF; data_a = 8'hA5;
        tick();
        idle();
        address_b = 9'h000;
        tick();
        check("basic_rd_000", q_b, 8'h5A);
        address_b = 9'h1FF;
        tick();
        check("basic_rd_1ff", q_b, 8'hA5);

        // Full sweep: A writes, then B reads back-to-back
        wren_a = 1'b1;
        for (int i = 0; i < 512; i++) begin
            address_a = 9'(i);
            data_a    = 8'(i) ^ 8'h3C;
            tick();
        end
        idle();
        address_b = 9'h000;
        tick();
        for (int i = 0; i < 512; i++) begin
            check($sformatf("sweep_%0d", i), q_b, 8'(i) ^ 8'h3C);
            address_b = 9'(i + 1);
            tick();
        end

        // Read-during-write
        wren_a = 1'b1; address_a = 9'h010; data_a = 8'h11;
        tick();
        address_a = 9'h010; data_a = 8'h22; address_b = 9'h010;
        tick();
        check("rdw_q_a_new", q_a, 8'h22);
        check("rdw_q_b_old", q_b, 8'h11);
        idle();
        tick();
        check("rdw_q_b_next", q_b, 8'h22);

        // Port B writes while A reads same address (sweep value 0x50^0x3C)
        wren_b = 1'b1; address_b = 9'h050; data_b = 8'h99; address_a = 9'h050;
        tick();
        check("xrd_q_a_old", q_a, 8'h6C);
        check("xrd_q_b_wt", q_b, 8'h99);
        idle();
        tick();
        check("xrd_q_a_next", q_a, 8'h99);

        // Write collision: B wins
        wren_a = 1'b1; address_a = 9'h020; data_a = 8'hAA;
        wren_b = 1'b1; address_b = 9'h020; data_b = 8'hBB;
        tick();
        check("coll_wt_a", q_a, 8'hAA);
        check("coll_wt_b", q_b, 8'hBB);
        idle();
        tick();
        check("coll_rd_a", q_a, 8'hBB);
        check("coll_rd_b", q_b, 8'hBB);

        // Reset suppresses writes and clears outputs, contents kept
        wren_a = 1'b1; address_a = 9'h030; data_a = 8'hFF;
        wren_b = 1'b1; address_b = 9'h031; data_b = 8'hFF;
        tick();
        check("pre_rst_q_a", q_a, 8'hFF);
        check("pre_rst_q_b", q_b, 8'hFF);
        reset = 1'b1;
        address_a = 9'h030; data_a = 8'h77;
        address_b = 9'h031; data_b = 8'h66;
        tick();
        check("rst_q_a", q_a, 8'h00);
        check("rst_q_b", q_b, 8'h00);
        reset = 1'b0;
        idle();
        tick();
        check("rst_keep_030", q_a, 8'hFF);
        check("rst_keep_031", q_b, 8'hFF);
        address_a = 9'h005; address_b = 9'h1FF;
        tick();
        check("rst_keep_005", q_a, 8'h39);
        check("rst_keep_1ff", q_b, 8'hC3);

        // Independent writes to different addresses
        wren_a = 1'b1; address_a = 9'h040; data_a = 8'h44;
        wren_b = 1'b1; address_b = 9'h041; data_b = 8'h55;
        tick();
        idle();
        address_a = 9'h041; address_b = 9'h040;
        tick();
        check("indep_rd_041", q_a, 8'h55);
        check("indep_rd_040", q_b, 8'h44);

        // Outputs hold with unchanged address and no writes
        tick();
        tick();
        check("hold_q_a", q_a, 8'h55);
        check("hold_q_b", q_b, 8'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
